// File: rtl/result_sel_pipe.sv
// result_sel_pipe: selects one of NUM_IN channels and stages {word, err} in a 2-entry skid buffer.
// Optional feature: define RESULT_SEL_PIPE_ERRCNT_EN to add a saturating illegal-select counter (err_count).
module result_sel_pipe #(
   parameter  int WIDTH        = 24,
   parameter  int NUM_IN       = 8,
   parameter  int ILLEGAL_MODE = 0,
   localparam int SEL_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

   localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] head_word_q, head_word_d;
   logic [WIDTH-1:0] tail_word_q, tail_word_d;
   logic [WIDTH-1:0] last_word_q, last_word_d;
   logic             head_err_q, head_err_d;
   logic             tail_err_q, tail_err_d;
   logic             in_ready_q, in_ready_d;

   logic             sel_legal;
   logic             accept;
   logic             emit;
   logic [WIDTH-1:0] new_word;
   logic             new_err;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
      new_word  = '0;
      sel_legal = ({1'b0, sel} < NUM_IN_L);
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            new_word = in_data[k*WIDTH +: WIDTH];
         end
      end
      if (!sel_legal) begin
         new_word = (ILLEGAL_MODE != 0) ? last_word_q : '0;
      end
      new_err = !sel_legal;
   end

   assign accept = in_valid && in_ready_q;
   assign emit   = (state_q != EMPTY) && out_ready;

   always_comb begin
      state_d     = state_q;
      head_word_d = head_word_q;
      head_err_d  = head_err_q;
      tail_word_d = tail_word_q;
      tail_err_d  = tail_err_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = ONE;
               head_word_d = new_word;
               head_err_d  = new_err;
            end
         end
         ONE: begin
            if (accept && emit) begin
               head_word_d = new_word;
               head_err_d  = new_err;
            end else if (accept) begin
               state_d     = TWO;
               tail_word_d = new_word;
               tail_err_d  = new_err;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low in TWO, so only the drain path exists here
            if (emit) begin
               state_d     = ONE;
               head_word_d = tail_word_q;
               head_err_d  = tail_err_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      last_word_d = (accept && sel_legal) ? new_word : last_word_q;
      in_ready_d  = (state_d != TWO);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         // NOTE: both buffer entries are cleared on reset; with only two words this keeps out_data deterministic.
         head_word_q <= '0;
         head_err_q  <= 1'b0;
         tail_word_q <= '0;
         tail_err_q  <= 1'b0;
         last_word_q <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         head_word_q <= head_word_d;
         head_err_q  <= head_err_d;
         tail_word_q <= tail_word_d;
         tail_err_q  <= tail_err_d;
         last_word_q <= last_word_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_word_q;
   assign out_err   = head_err_q;

`ifdef RESULT_SEL_PIPE_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (accept && !sel_legal && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count_q <= 8'd0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_result_sel_pipe.sv
// Bench for result_sel_pipe: three instances (8ch mode0, 6ch mode0, 6ch mode1) share one stimulus
// and are compared each cycle against a queue-based model plus directed literal expectations.
module tb_result_sel_pipe;

   localparam int W  = 24;
   localparam int ND = 3;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           out_ready = 1'b0;
   logic [2:0]     sel       = '0;
   logic [8*W-1:0] in_data   = '0;

   logic [ND-1:0]  in_ready;
   logic [ND-1:0]  out_valid;
   logic [ND-1:0]  out_err;
   logic [W-1:0]   out_data [ND];
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
   logic [7:0]     err_count [ND];
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;

   // model state: per-instance queue of {err, word}, last legal word, ready, error count
   int           m_num  [ND] = '{8, 6, 6};
   int           m_mode [ND] = '{0, 0, 1};
   logic [W:0]   mq     [ND][$];
   logic [W-1:0] m_last [ND];
   logic         m_rdy  [ND];
   int           m_cnt  [ND];

   always #5 clk = ~clk;

   result_sel_pipe #(.WIDTH(W), .NUM_IN(8), .ILLEGAL_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready[0]), .out_data(out_data[0]), .out_err(out_err[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready)
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
      , .err_count(err_count[0])
`endif
   );

   result_sel_pipe #(.WIDTH(W), .NUM_IN(6), .ILLEGAL_MODE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[6*W-1:0]), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready[1]), .out_data(out_data[1]), .out_err(out_err[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready)
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
      , .err_count(err_count[1])
`endif
   );

   result_sel_pipe #(.WIDTH(W), .NUM_IN(6), .ILLEGAL_MODE(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[6*W-1:0]), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready[2]), .out_data(out_data[2]), .out_err(out_err[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready)
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
      , .err_count(err_count[2])
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Advance the model by one accepted-edge worth of behaviour, using the inputs present at the edge.
   task automatic model_step();
      logic [W-1:0] w;
      logic         e;
      logic         acc;
      logic         emt;
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            mq[d].delete();
            m_last[d] = '0;
            m_cnt[d]  = 0;
         end else begin
            acc = in_valid && m_rdy[d];
            emt = (mq[d].size() != 0) && out_ready;
            if (int'(sel) < m_num[d]) begin
               w = in_data[int'(sel)*W +: W];
               e = 1'b0;
               if (acc) m_last[d] = w;
            end else begin
               e = 1'b1;
               w = (m_mode[d] != 0) ? m_last[d] : '0;
               if (acc && m_cnt[d] < 255) m_cnt[d]++;
            end
            if (emt) void'(mq[d].pop_front());
            if (acc) mq[d].push_back({e, w});
         end
         m_rdy[d] = (mq[d].size() < 2);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_chans();
      for (int k = 0; k < 8; k++) in_data[k*W +: W] = (W'(k) << 16) | W'(24'hAB);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < ND; d++) begin
            check($sformatf("model_in_ready[%0d]", d), 32'(in_ready[d]), 32'(m_rdy[d]));
            check($sformatf("model_out_valid[%0d]", d), 32'(out_valid[d]), 32'(mq[d].size() != 0));
            if (mq[d].size() != 0) begin
               check($sformatf("model_out_data[%0d]", d), 32'(out_data[d]), 32'(mq[d][0][W-1:0]));
               check($sformatf("model_out_err[%0d]", d), 32'(out_err[d]), 32'(mq[d][0][W]));
            end
`ifdef RESULT_SEL_PIPE_ERRCNT_EN
            check($sformatf("model_err_count[%0d]", d), 32'(err_count[d]), 32'(m_cnt[d]));
`endif
         end
      end
   end

   initial begin
      int drops;
      int valid_cycles;
      for (int d = 0; d < ND; d++) m_rdy[d] = 1'b1;
      set_chans();

      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      for (int d = 0; d < ND; d++) begin
         check($sformatf("rst_out_valid[%0d]", d), 32'(out_valid[d]), 0);
         check($sformatf("rst_in_ready[%0d]", d), 32'(in_ready[d]), 1);
         check($sformatf("rst_out_data[%0d]", d), 32'(out_data[d]), 0);
         check($sformatf("rst_out_err[%0d]", d), 32'(out_err[d]), 0);
      end
      chk_en = 1'b1;
      rst_n  = 1'b1;
      tick();

      // fill-and-read: sel 5 appears one cycle after accept
      out_ready = 1'b1;
      sel       = 3'd5;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      sel       = 3'd0;
      check("fill_valid", 32'(out_valid[0]), 1);
      check("fill_data", 32'(out_data[0]), 32'h0500AB);
      check("fill_err", 32'(out_err[0]), 0);
      tick();
      check("fill_drained", 32'(out_valid[0]), 0);

      // backpressure: two accepted, third held off, then drained in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 3'd1;
      tick();
      sel = 3'd2;
      tick();
      check("bp_ready_low", 32'(in_ready[0]), 0);
      check("bp_head", 32'(out_data[0]), 32'h0100AB);
      sel = 3'd3;
      tick();
      check("bp_hold_data", 32'(out_data[0]), 32'h0100AB);
      check("bp_hold_ready", 32'(in_ready[0]), 0);
      out_ready = 1'b1;
      tick();
      check("bp_second", 32'(out_data[0]), 32'h0200AB);
      check("bp_ready_back", 32'(in_ready[0]), 1);
      tick();
      check("bp_third", 32'(out_data[0]), 32'h0300AB);
      check("bp_third_valid", 32'(out_valid[0]), 1);
      in_valid = 1'b0;
      in_data  = '1;
      tick();
      check("bp_empty", 32'(out_valid[0]), 0);
      set_chans();

      // illegal select after a legal sel 2
      in_valid = 1'b1;
      sel      = 3'd2;
      tick();
      sel = 3'd7;
      tick();
      in_valid = 1'b0;
      check("ill_m0_data", 32'(out_data[1]), 0);
      check("ill_m0_err", 32'(out_err[1]), 1);
      check("ill_m1_data", 32'(out_data[2]), 32'h0200AB);
      check("ill_m1_err", 32'(out_err[2]), 1);
      check("ill_8ch_data", 32'(out_data[0]), 32'h0700AB);
      check("ill_8ch_err", 32'(out_err[0]), 0);
      tick();

      // mode 1 right after reset re-emits zero
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b1;
      sel      = 3'd7;
      tick();
      in_valid = 1'b0;
      check("ill_m1_rst_data", 32'(out_data[2]), 0);
      check("ill_m1_rst_err", 32'(out_err[2]), 1);
      tick();

      // streaming with random data and selects
      drops        = 0;
      valid_cycles = 0;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         sel = 3'($urandom_range(0, 7));
         for (int k = 0; k < 8; k++) in_data[k*W +: W] = W'($urandom);
         tick();
         if (in_ready != 3'b111) drops++;
         if (out_valid[0]) valid_cycles++;
      end
      in_valid = 1'b0;
      check("stream_ready_drops", drops, 0);
      check("stream_valid_cycles", valid_cycles, 100);
      tick();
      set_chans();

      // reset while holding two words
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 3'd4;
      tick();
      sel = 3'd6;
      tick();
      in_valid = 1'b0;
      check("mr_full", 32'(in_ready[0]), 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_out_valid", 32'(out_valid), 0);
      check("mr_in_ready", 32'(in_ready), 32'h7);
      out_ready = 1'b1;
      tick();
      tick();
      check("mr_never_emitted", 32'(out_valid), 0);

`ifdef RESULT_SEL_PIPE_ERRCNT_EN
      // error counter saturation and reset
      in_valid = 1'b1;
      sel      = 3'd7;
      for (int i = 0; i < 300; i++) tick();
      in_valid = 1'b0;
      check("errcnt_sat_b", 32'(err_count[1]), 255);
      check("errcnt_sat_c", 32'(err_count[2]), 255);
      check("errcnt_legal_a", 32'(err_count[0]), 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("errcnt_rst", 32'(err_count[1]), 0);
`endif

      tick();
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/result_sel_pipe.md
RESULT_SEL_PIPE -- requirements
Module: result_sel_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24: data width of each input channel and of the output.
REQ-002 SHALL have parameter NUM_IN, default 8, legal range 2..16: number of selectable channels.
REQ-003 SHALL have parameter ILLEGAL_MODE, default 0: 0 = illegal select yields zero, 1 = illegal select re-emits the last legally selected word.
REQ-004 SHALL derive localparam SEL_W = clog2(NUM_IN), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel index, qualified by in_valid.
REQ-009 in_valid  input  1  upstream offers {in_data, sel}.
REQ-010 in_ready  output  1  block accepts this cycle; driven only from a register.
REQ-011 out_data  output  WIDTH  selected word at the buffer head.
REQ-012 out_err  output  1  the head word came from an illegal select (sel >= NUM_IN).
REQ-013 out_valid  output  1  head word is valid.
REQ-014 out_ready  input  1  downstream consumes the head word this cycle.

Function
REQ-015 SHALL accept a transfer on any rising edge where in_valid && in_ready, and emit one on any edge where out_valid && out_ready.
REQ-016 SHALL compute, for a legal sel, word = channel[sel], err = 0.
REQ-017 SHALL compute, for sel >= NUM_IN, err = 1 and word = 0 (ILLEGAL_MODE 0) or the last legally accepted word, 0 after reset (ILLEGAL_MODE 1).
REQ-018 SHALL update the last-legal-word register only on an accepted transfer with a legal sel.
REQ-019 SHALL store {word, err} in a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-020 EMPTY: accept -> ONE.
REQ-021 ONE: accept and no emit -> TWO; emit and no accept -> EMPTY; accept and emit together -> ONE with the new word at the head.
REQ-022 TWO: emit -> ONE with the second entry promoted to head; no accept is possible.
REQ-023 SHALL register in_ready = (next state != TWO), giving full throughput with a 1-cycle accept-to-out_valid latency.
REQ-024 SHALL drive out_valid = (state != EMPTY), and SHALL hold out_data and out_err stable while out_valid && !out_ready.
REQ-025 SHALL preserve ordering; no word is dropped or duplicated.
REQ-026 SHALL ignore in_data and sel whenever the transfer is not accepted.

Reset
REQ-027 SHALL, while rst_n = 0 at a clock edge, force state EMPTY, out_valid 0, out_data 0, out_err 0, in_ready 1 and the last-legal-word register 0.
REQ-028 SHALL discard buffered words when reset is asserted mid-operation, with no emit on that edge.
REQ-029 SHALL produce, on the first edge after rst_n rises, identical state to that produced at power-up reset.

Configuration
REQ-030 SHALL, when macro RESULT_SEL_PIPE_ERRCNT_EN is defined, add output err_count, 8 bits, which increments on each accepted illegal-select transfer, saturates at 255 and is reset to 0.
REQ-031 SHALL, without RESULT_SEL_PIPE_ERRCNT_EN, omit the err_count port and logic entirely; all other behaviour is identical.

Verification
REQ-032 Fill-and-read: WIDTH=24, NUM_IN=8, channel k = 0x10000*k + 0xAB, sel=5, out_ready=1 -> out_data=0x0500AB, out_err=0, one cycle after accept.
REQ-033 Backpressure: out_ready=0, push sels 1, 2, 3 -> two accepted, in_ready=0 after the 2nd; raise out_ready -> outputs chan1, chan2, then chan3, in order, no loss.
REQ-034 Illegal select: NUM_IN=6, sel=7, ILLEGAL_MODE=0 -> out_data=0, out_err=1; with ILLEGAL_MODE=1 after legal sel=2 (0x0200AB) -> out_data=0x0200AB, out_err=1.
REQ-035 Streaming: in_valid=1, out_ready=1, 100 random sels -> one output per cycle after the first, in_ready never drops, scoreboard matches.
REQ-036 Reset mid-run: TWO state, rst_n=0 for 1 cycle -> out_valid=0, in_ready=1 next cycle, buffered words never emitted.
REQ-037 With RESULT_SEL_PIPE_ERRCNT_EN: 300 accepted illegal selects -> err_count=255; reset -> 0.
